// File: rtl/decoder.sv
// MIPS instruction decoder: combinational ALU/mul-div control from IR, plus a
// sticky flag recording that an unrecognised instruction was ever sampled.
module decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic [3:0]  ALUctr,
    output logic [1:0]  MDWrite,
    output logic [2:0]  MDcal,
    output logic        start,
    output logic        ri,
    output logic        ri_seen
);

    localparam logic [3:0] ALU_ADD        = 4'd0;
    localparam logic [3:0] ALU_SUB        = 4'd1;
    localparam logic [3:0] ALU_AND        = 4'd2;
    localparam logic [3:0] ALU_OR         = 4'd3;
    localparam logic [3:0] ALU_XOR        = 4'd4;
    localparam logic [3:0] ALU_NOR        = 4'd5;
    localparam logic [3:0] ALU_LEFT       = 4'd6;
    localparam logic [3:0] ALU_SIGN_RIGHT = 4'd7;
    localparam logic [3:0] ALU_ZERO_RIGHT = 4'd8;
    localparam logic [3:0] ALU_SIGN_LESS  = 4'd9;
    localparam logic [3:0] ALU_ZERO_LESS  = 4'd10;

    localparam logic [1:0] MDW_NONE = 2'd0;
    localparam logic [1:0] MDW_WHI  = 2'd1;
    localparam logic [1:0] MDW_WLO  = 2'd2;

    localparam logic [2:0] MDC_NONE       = 3'd0;
    localparam logic [2:0] MDC_MULTS      = 3'd1;
    localparam logic [2:0] MDC_SIGN_MULTS = 3'd2;
    localparam logic [2:0] MDC_DIVS       = 3'd3;
    localparam logic [2:0] MDC_SIGN_DIVS  = 3'd4;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_alu;
    logic [1:0] w_mdw;
    logic [2:0] w_mdc;
    logic       w_ri;
    logic       r_ri_seen;

    assign w_op    = IR[31:26];
    assign w_funct = IR[5:0];

    // Anything not matched below stays at the illegal-instruction defaults.
    always_comb begin
        w_alu = ALU_ADD;
        w_mdw = MDW_NONE;
        w_mdc = MDC_NONE;
        w_ri  = 1'b1;
        if (w_op == 6'b000000) begin
            w_ri = 1'b0;
            case (w_funct)
                6'b100000, 6'b100001: w_alu = ALU_ADD;
                6'b100010, 6'b100011: w_alu = ALU_SUB;
                6'b100100:            w_alu = ALU_AND;
                6'b100101:            w_alu = ALU_OR;
                6'b100110:            w_alu = ALU_XOR;
                6'b100111:            w_alu = ALU_NOR;
                6'b101010:            w_alu = ALU_SIGN_LESS;
                6'b101011:            w_alu = ALU_ZERO_LESS;
                6'b000000, 6'b000100: w_alu = ALU_LEFT;
                6'b000010, 6'b000110: w_alu = ALU_ZERO_RIGHT;
                6'b000011, 6'b000111: w_alu = ALU_SIGN_RIGHT;
                6'b011000:            w_mdc = MDC_SIGN_MULTS;
                6'b011001:            w_mdc = MDC_MULTS;
                6'b011010:            w_mdc = MDC_SIGN_DIVS;
                6'b011011:            w_mdc = MDC_DIVS;
                6'b010001:            w_mdw = MDW_WHI;
                6'b010011:            w_mdw = MDW_WLO;
                6'b010000, 6'b010010,
                6'b001000, 6'b001001: w_alu = ALU_ADD;
                default:              w_ri  = 1'b1;
            endcase
        end else begin
            w_ri = 1'b0;
            case (w_op)
                6'b001000, 6'b001001: w_alu = ALU_ADD;
                6'b001010:            w_alu = ALU_SIGN_LESS;
                6'b001011:            w_alu = ALU_ZERO_LESS;
                6'b001100:            w_alu = ALU_AND;
                6'b001101, 6'b001111: w_alu = ALU_OR;
                6'b001110:            w_alu = ALU_XOR;
                6'b100000, 6'b100001, 6'b100011,
                6'b100100, 6'b100101: w_alu = ALU_ADD;
                6'b101000, 6'b101001, 6'b101011: w_alu = ALU_ADD;
                6'b000100, 6'b000101: w_alu = ALU_SUB;
                6'b000010, 6'b000011: w_alu = ALU_ADD;
                default:              w_ri  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ri_seen <= 1'b0;
        else
            r_ri_seen <= r_ri_seen | w_ri;
    end

    assign ALUctr  = w_alu;
    assign MDWrite = w_mdw;
    assign MDcal   = w_mdc;
    assign start   = (w_mdc != MDC_NONE);
    assign ri      = w_ri;
    assign ri_seen = r_ri_seen;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: table of hand-decoded instructions plus sequences for the
// sticky ri_seen flag and its asynchronous reset.
module tb_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic [3:0]  ALUctr;
    logic [1:0]  MDWrite;
    logic [2:0]  MDcal;
    logic        start;
    logic        ri;
    logic        ri_seen;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  alu;
        logic [1:0]  mdw;
        logic [2:0]  mdc;
        logic        st;
        logic        ri;
    } vec_t;

    vec_t vecs[$];

    decoder dut (
        .clk     (clk),
        .reset   (reset),
        .IR      (IR),
        .ALUctr  (ALUctr),
        .MDWrite (MDWrite),
        .MDcal   (MDcal),
        .start   (start),
        .ri      (ri),
        .ri_seen (ri_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addv(input logic [31:0] ir, input int alu, input int mdw,
                        input int mdc, input logic st, input logic r);
        vec_t v;
        v.ir  = ir;
        v.alu = 4'(alu);
        v.mdw = 2'(mdw);
        v.mdc = 3'(mdc);
        v.st  = st;
        v.ri  = r;
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v);
        n_checks++;
        if ({ALUctr, MDWrite, MDcal, start, ri} !== {v.alu, v.mdw, v.mdc, v.st, v.ri}) begin
            n_errors++;
            $display("FAIL decode IR=%08h: got alu=%0d mdw=%0d mdc=%0d st=%0b ri=%0b expected alu=%0d mdw=%0d mdc=%0d st=%0b ri=%0b",
                     v.ir, ALUctr, MDWrite, MDcal, start, ri, v.alu, v.mdw, v.mdc, v.st, v.ri);
        end
    endtask

    initial begin
        // R-type ALU
        addv(32'h02328020, 0, 0, 0, 0, 0);
        addv(32'h00000021, 0, 0, 0, 0, 0);
        addv(32'h00000022, 1, 0, 0, 0, 0);
        addv(32'h00000023, 1, 0, 0, 0, 0);
        addv(32'h00000024, 2, 0, 0, 0, 0);
        addv(32'h00000025, 3, 0, 0, 0, 0);
        addv(32'h00000026, 4, 0, 0, 0, 0);
        addv(32'h00000027, 5, 0, 0, 0, 0);
        addv(32'h0000002A, 9, 0, 0, 0, 0);
        addv(32'h0000002B, 10, 0, 0, 0, 0);
        addv(32'h00000000, 6, 0, 0, 0, 0);
        addv(32'h00000004, 6, 0, 0, 0, 0);
        addv(32'h00000002, 8, 0, 0, 0, 0);
        addv(32'h00000006, 8, 0, 0, 0, 0);
        addv(32'h00118083, 7, 0, 0, 0, 0);
        addv(32'h00000007, 7, 0, 0, 0, 0);
        // mul/div and HI/LO writes
        addv(32'h02320018, 0, 0, 2, 1, 0);
        addv(32'h00000019, 0, 0, 1, 1, 0);
        addv(32'h0000001A, 0, 0, 4, 1, 0);
        addv(32'h0232001B, 0, 0, 3, 1, 0);
        addv(32'h02200011, 0, 1, 0, 0, 0);
        addv(32'h02200013, 0, 2, 0, 0, 0);
        addv(32'h00000010, 0, 0, 0, 0, 0);
        addv(32'h00000012, 0, 0, 0, 0, 0);
        addv(32'h03E00008, 0, 0, 0, 0, 0);
        addv(32'h00000009, 0, 0, 0, 0, 0);
        // R-type illegal funct
        addv(32'h00000001, 0, 0, 0, 0, 1);
        addv(32'h0000003F, 0, 0, 0, 0, 1);
        addv(32'h02320030, 0, 0, 0, 0, 1);
        // I-type and jumps
        addv(32'h20000000, 0, 0, 0, 0, 0);
        addv(32'h24000018, 0, 0, 0, 0, 0);
        addv(32'h2A300005, 9, 0, 0, 0, 0);
        addv(32'h2C000000, 10, 0, 0, 0, 0);
        addv(32'h30000000, 2, 0, 0, 0, 0);
        addv(32'h34000000, 3, 0, 0, 0, 0);
        addv(32'h38000000, 4, 0, 0, 0, 0);
        addv(32'h3C000000, 3, 0, 0, 0, 0);
        addv(32'h80000000, 0, 0, 0, 0, 0);
        addv(32'h84000000, 0, 0, 0, 0, 0);
        addv(32'h8C000000, 0, 0, 0, 0, 0);
        addv(32'h90000000, 0, 0, 0, 0, 0);
        addv(32'h94000000, 0, 0, 0, 0, 0);
        addv(32'hA0000000, 0, 0, 0, 0, 0);
        addv(32'hA4000000, 0, 0, 0, 0, 0);
        addv(32'hAC000000, 0, 0, 0, 0, 0);
        addv(32'h10000000, 1, 0, 0, 0, 0);
        addv(32'h14000000, 1, 0, 0, 0, 0);
        addv(32'h08000000, 0, 0, 0, 0, 0);
        addv(32'h0C000000, 0, 0, 0, 0, 0);
        // illegal opcodes, including ones whose low bits mimic mul/div/shift
        addv(32'hFC000000, 0, 0, 0, 0, 1);
        addv(32'h88000000, 0, 0, 0, 0, 1);
        addv(32'h04000018, 0, 0, 0, 0, 1);
        addv(32'h1C000003, 0, 0, 0, 0, 1);

        // Reset held with an illegal IR: flag stays clear, decode still live.
        reset = 1'b1;
        IR    = 32'hFC000000;
        @(negedge clk);
        @(negedge clk);
        check1("ri_during_reset", ri, 1'b1);
        check1("ri_seen_held_in_reset", ri_seen, 1'b0);

        IR    = 32'h02328020;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("ri_seen_after_release", ri_seen, 1'b0);

        // Illegal IR: combinational ri now, flag after the next edge.
        IR = 32'hFC000000;
        #1;
        check1("ri_comb", ri, 1'b1);
        check1("ri_seen_before_edge", ri_seen, 1'b0);
        @(negedge clk);
        check1("ri_seen_set", ri_seen, 1'b1);
        IR = 32'h02328020;
        @(negedge clk);
        @(negedge clk);
        check1("ri_legal_again", ri, 1'b0);
        check1("ri_seen_sticky", ri_seen, 1'b1);

        // Asynchronous reset mid-cycle clears the flag at once.
        #2;
        reset = 1'b1;
        #1;
        check1("ri_seen_async_clear", ri_seen, 1'b0);
        IR = 32'hFC000000;
        @(negedge clk);
        check1("ri_seen_reset_blocks", ri_seen, 1'b0);
        IR = 32'h02328020;
        reset = 1'b0;
        @(negedge clk);
        check1("ri_seen_after_rerelease", ri_seen, 1'b0);

        // Table: one vector per clock, checked away from the edge.
        foreach (vecs[i]) begin
            IR = vecs[i].ir;
            #1;
            check_vec(vecs[i]);
            @(negedge clk);
        end
        check1("ri_seen_after_table", ri_seen, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
